// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - request/response bus between the datapath and its memory
interface data_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_byte_enable;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;

  // Requester side: the datapath control word drives the request fields.
  modport master (
    output mem_read,
    output mem_write,
    output mem_byte_enable,
    output mem_address,
    output mem_wdata,
    input  mem_rdata,
    input  mem_resp
  );

  // Responder side: the memory model answers with data and a completion pulse.
  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_byte_enable,
    input  mem_address,
    input  mem_wdata,
    output mem_rdata,
    output mem_resp
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency word SRAM responder for the datapath memory bus
module data_mem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  data_mem_responder_if.slave  bus,
  output logic                 busy,
  output logic                 protocol_err
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [7:0] cnt;
  logic [7:0] cnt_nxt;

  // Request fields frozen at capture; the bus is ignored while waiting.
  logic [ADDR_BITS-1:0] cap_idx;
  logic [15:0]          cap_wdata;
  logic [1:0]           cap_be;
  logic                 cap_write;

  // Access performed on the edge that enters RESP.
  logic                 capture;
  logic                 access;
  logic                 acc_write;
  logic [ADDR_BITS-1:0] acc_idx;
  logic [15:0]          acc_wdata;
  logic [1:0]           acc_be;

  logic [15:0] sram [0:DEPTH-1];
  logic [15:0] rdata_q;
  logic        perr_q;

  logic                 req;
  logic                 both_ops;
  logic [ADDR_BITS-1:0] live_idx;

  // Bit 0 selects a byte within the word and the upper bits alias, so neither
  // participates in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_address[15:ADDR_BITS+1], bus.mem_address[0]};

  assign req      = bus.mem_read | bus.mem_write;
  assign both_ops = bus.mem_read & bus.mem_write;
  assign live_idx = bus.mem_address[ADDR_BITS:1];

  // State register and latency counter; reset abandons any request in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state, counter and the single access strobe.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    access    = 1'b0;
    acc_write = cap_write;
    acc_idx   = cap_idx;
    acc_wdata = cap_wdata;
    acc_be    = cap_be;
    case (state)
      IDLE: begin
        if (req) begin
          capture = 1'b1;
          cnt_nxt = 8'(LATENCY - 1);
          if (LATENCY == 1) begin
            // No wait phase: the access uses the live bus on the capture edge.
            state_nxt = RESP;
            access    = 1'b1;
            acc_write = bus.mem_write;
            acc_idx   = live_idx;
            acc_wdata = bus.mem_wdata;
            acc_be    = bus.mem_byte_enable;
          end else begin
            state_nxt = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 8'd0) begin
          state_nxt = RESP;
          access    = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      RESP: begin
        // Requests are not sampled here; the requester drops them on this edge.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Capture registers; a simultaneous read and write is treated as a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_idx   <= '0;
      cap_wdata <= 16'h0000;
      cap_be    <= 2'b00;
      cap_write <= 1'b0;
    end else if (capture) begin
      cap_idx   <= live_idx;
      cap_wdata <= bus.mem_wdata;
      cap_be    <= bus.mem_byte_enable;
      cap_write <= bus.mem_write;
    end
  end

  // Sticky flag for a request that asked for both read and write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perr_q <= 1'b0;
    end else if (capture && both_ops) begin
      perr_q <= 1'b1;
    end
  end

  // Read data register; only a completed read updates it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= 16'h0000;
    end else if (access && !acc_write) begin
      rdata_q <= sram[acc_idx];
    end
  end

  // Storage array, deliberately left uninitialised by reset; byte-masked writes.
  always_ff @(posedge clk) begin
    if (access && acc_write) begin
      if (acc_be[0]) begin
        sram[acc_idx][7:0] <= acc_wdata[7:0];
      end
      if (acc_be[1]) begin
        sram[acc_idx][15:8] <= acc_wdata[15:8];
      end
    end
  end

  assign bus.mem_resp  = (state == RESP);
  assign bus.mem_rdata = rdata_q;
  assign busy          = (state != IDLE);
  assign protocol_err  = perr_q;

endmodule
